// File: rtl/ram_owner_arbiter_pkg.sv
// Shared definitions for the RAM owner arbiter: FSM state encoding, owner codes
// and the state-to-owner decode used by both the FSM and the RAM mux.
package ram_owner_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_PROG   = 3'd3,
        ST_SCREEN = 3'd4
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE   = 2'd0;
    localparam logic [1:0] OWNER_CPU    = 2'd1;
    localparam logic [1:0] OWNER_PROG   = 2'd2;
    localparam logic [1:0] OWNER_SCREEN = 2'd3;

    // DRAIN still belongs to the CPU so its in-flight address stays stable on the RAM.
    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] o;
        case (st)
            ST_RUN,
            ST_DRAIN:  o = OWNER_CPU;
            ST_PROG:   o = OWNER_PROG;
            ST_SCREEN: o = OWNER_SCREEN;
            default:   o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ram_owner_arbiter_timer.sv
// Loadable saturating counter (up or down) with a terminal-value flag.
// Load has priority over counting; the count never wraps.
module ram_owner_arbiter_timer #(
    parameter int W        = 8,
    parameter bit COUNT_UP = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_term
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] FULL = {W{1'b1}};

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_val;
        end else if (i_en) begin
            if (COUNT_UP) begin
                if (r_count != FULL) w_count_next = r_count + ONE;
            end else begin
                if (r_count != '0) w_count_next = r_count - ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_term = (r_count == i_term);

endmodule

// File: rtl/ram_owner_arbiter.sv
// Single-port RAM owner: arbitrates programmer, screen scanner and 6502 CPU,
// halting the CPU via RDY before handing the RAM away and pulsing CPU reset at boot.
module ram_owner_arbiter
    import ram_owner_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int RESET_CYCLES = 8,
    parameter int SCR_MAX_HOLD = 64,
    parameter int CPU_MIN_RUN  = 4
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              prog_req,
    input  logic              prog_done,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic              prog_we,
    input  logic              scr_req,
    input  logic [ADDR_W-1:0] scr_addr,
    output logic              scr_gnt,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic              cpu_rdy,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [1:0]        owner
);

    localparam int CNT_MAX_A = (RESET_CYCLES > SCR_MAX_HOLD) ? RESET_CYCLES : SCR_MAX_HOLD;
    localparam int CNT_MAX   = (CNT_MAX_A > CPU_MIN_RUN) ? CNT_MAX_A : CPU_MIN_RUN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SCR_MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(CPU_MIN_RUN);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic             w_phase_done;
    logic             w_phase_load;
    logic             w_phase_en;
    logic [CNT_W-1:0] w_phase_term_val;
    logic             w_cool_zero;
    logic             w_cool_load;
    logic             w_cool_en;

    // One up-counter serves both BOOT length and SCREEN hold; it restarts on every state change.
    assign w_phase_load     = (w_state_next != r_state);
    assign w_phase_en       = (r_state == ST_BOOT) || (r_state == ST_SCREEN);
    assign w_phase_term_val = (r_state == ST_BOOT) ? BOOT_LAST : HOLD_LAST;

    ram_owner_arbiter_timer #(
        .W        (CNT_W),
        .COUNT_UP (1'b1)
    ) u_phase_timer (
        .i_clk      (clk_ram),
        .i_rst_n    (reset_n),
        .i_load     (w_phase_load),
        .i_load_val ('0),
        .i_en       (w_phase_en),
        .i_term     (w_phase_term_val),
        .o_term     (w_phase_done)
    );

    // Cooldown guarantees the CPU some RUN cycles after the screen used up its hold budget.
    assign w_cool_load = (r_state == ST_SCREEN) && (w_state_next == ST_RUN);
    assign w_cool_en   = (r_state == ST_RUN);

    ram_owner_arbiter_timer #(
        .W        (CNT_W),
        .COUNT_UP (1'b0)
    ) u_cool_timer (
        .i_clk      (clk_ram),
        .i_rst_n    (reset_n),
        .i_load     (w_cool_load),
        .i_load_val (COOL_LOAD),
        .i_en       (w_cool_en),
        .i_term     ('0),
        .o_term     (w_cool_zero)
    );

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: begin
                if (prog_req)          w_state_next = ST_PROG;
                else if (w_phase_done) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (prog_req || (scr_req && w_cool_zero)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (prog_req)     w_state_next = ST_PROG;
                else if (scr_req) w_state_next = ST_SCREEN;
                else              w_state_next = ST_RUN;
            end
            ST_PROG: begin
                if (prog_done)     w_state_next = ST_BOOT;
                else if (!prog_req) w_state_next = ST_RUN;
            end
            ST_SCREEN: begin
                if (prog_req)                       w_state_next = ST_PROG;
                else if (!scr_req || w_phase_done)  w_state_next = ST_RUN;
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        owner     = owner_of(r_state);
        cpu_rdy   = (r_state == ST_RUN);
        cpu_rst   = (r_state == ST_BOOT);
        scr_gnt   = (r_state == ST_SCREEN);
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (owner)
            OWNER_CPU: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = (r_state == ST_RUN) && cpu_we;
            end
            OWNER_PROG: begin
                ram_addr  = prog_addr;
                ram_wdata = prog_wdata;
                ram_we    = prog_we;
            end
            OWNER_SCREEN: begin
                ram_addr  = scr_addr;
            end
            default: begin
                ram_addr  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_owner_arbiter.sv
// Scoreboard bench for ram_owner_arbiter: directed scenarios plus randomized
// requests, checked every cycle against a behavioural ownership model.
module tb_ram_owner_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int RC  = 8;
    localparam int SMH = 64;
    localparam int CMR = 4;

    localparam int PH_BOOT   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_DRAIN  = 2;
    localparam int PH_PROG   = 3;
    localparam int PH_SCREEN = 4;

    logic          clk_ram = 1'b0;
    logic          reset_n = 1'b0;
    logic          prog_req = 1'b0, prog_done = 1'b0, prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_wdata = '0;
    logic          scr_req = 1'b0;
    logic [AW-1:0] scr_addr = '0;
    logic          scr_gnt;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic          cpu_rdy, cpu_rst, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [1:0]    owner;

    always #5 clk_ram = ~clk_ram;

    ram_owner_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RESET_CYCLES(RC), .SCR_MAX_HOLD(SMH), .CPU_MIN_RUN(CMR)
    ) dut (
        .clk_ram(clk_ram), .reset_n(reset_n),
        .prog_req(prog_req), .prog_done(prog_done), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_we(prog_we),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_gnt(scr_gnt),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .cpu_rst(cpu_rst),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .owner(owner)
    );

    int tests = 0;
    int fails = 0;

    // Model: who holds the RAM this cycle plus the remaining budgets that end each phase.
    int m_phase;
    int m_boot_left;
    int m_budget;
    int m_cool;

    typedef struct {
        logic [1:0]    owner;
        logic          rdy, rst, gnt, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit            chk_wd;
        int            phase;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        m_phase     = PH_BOOT;
        m_boot_left = RC;
        m_budget    = SMH;
        m_cool      = 0;
    endtask

    task automatic model_advance();
        bit go;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            PH_BOOT: begin
                if (prog_req) m_phase = PH_PROG;
                else begin
                    m_boot_left--;
                    if (m_boot_left == 0) m_phase = PH_RUN;
                end
            end
            PH_RUN: begin
                go = prog_req || (scr_req && m_cool == 0);
                if (m_cool > 0) m_cool--;
                if (go) m_phase = PH_DRAIN;
            end
            PH_DRAIN: begin
                if (prog_req) m_phase = PH_PROG;
                else if (scr_req) begin
                    m_phase  = PH_SCREEN;
                    m_budget = SMH;
                end else m_phase = PH_RUN;
            end
            PH_PROG: begin
                if (prog_done) begin
                    m_phase     = PH_BOOT;
                    m_boot_left = RC;
                end else if (!prog_req) m_phase = PH_RUN;
            end
            default: begin
                if (prog_req) m_phase = PH_PROG;
                else begin
                    m_budget--;
                    if (!scr_req || m_budget == 0) begin
                        m_phase = PH_RUN;
                        m_cool  = CMR;
                    end
                end
            end
        endcase
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.phase = m_phase;
        e.rdy   = (m_phase == PH_RUN);
        e.rst   = (m_phase == PH_BOOT);
        e.gnt   = (m_phase == PH_SCREEN);
        e.we    = 1'b0;
        e.addr  = '0;
        e.wd    = '0;
        case (m_phase)
            PH_RUN, PH_DRAIN: begin
                e.owner = 2'd1;
                e.addr  = cpu_addr;
                e.wd    = cpu_wdata;
                e.we    = (m_phase == PH_RUN) ? cpu_we : 1'b0;
            end
            PH_PROG: begin
                e.owner = 2'd2;
                e.addr  = prog_addr;
                e.wd    = prog_wdata;
                e.we    = prog_we;
            end
            PH_SCREEN: begin
                e.owner = 2'd3;
                e.addr  = scr_addr;
            end
            default: e.owner = 2'd0;
        endcase
        e.chk_wd = (e.owner != 2'd3);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst_v, input bit p_req, input bit p_done, input bit p_we,
                        input bit s_req, input bit c_we,
                        input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                        input logic [AW-1:0] p_addr, input logic [DW-1:0] p_wd,
                        input logic [AW-1:0] s_addr);
        @(posedge clk_ram);
        #1;
        model_advance();
        reset_n    = rst_v;
        prog_req   = p_req;
        prog_done  = p_done;
        prog_we    = p_we;
        prog_addr  = p_addr;
        prog_wdata = p_wd;
        scr_req    = s_req;
        scr_addr   = s_addr;
        cpu_we     = c_we;
        cpu_addr   = c_addr;
        cpu_wdata  = c_wd;
        if (!reset_n) model_reset();
        sb.push_back(expect_now());
    endtask

    task automatic rstep(input bit p_req, input bit p_done, input bit s_req);
        step(1'b1, p_req, p_done, 1'($urandom), s_req, 1'($urandom),
             16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
    endtask

    // Asserts reset between clock edges and checks that outputs fall back without a clock.
    task automatic reset_mid_cycle();
        @(posedge clk_ram);
        #1;
        model_advance();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst cpu_rst", 32'(cpu_rst), 32'd1);
        check("async_rst ram_we",  32'(ram_we),  32'd0);
        check("async_rst cpu_rdy", 32'(cpu_rdy), 32'd0);
        check("async_rst owner",   32'(owner),   32'd0);
        model_reset();
        sb.push_back(expect_now());
    endtask

    task automatic wait_phase(input int ph, input bit p_req, input bit s_req, input string name);
        int n;
        n = 0;
        while (m_phase != ph && n < 200) begin
            rstep(p_req, 1'b0, s_req);
            n++;
        end
        tests++;
        if (m_phase != ph) begin
            fails++;
            $display("FAIL %s: model phase %0d expected %0d after %0d cycles", name, m_phase, ph, n);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per clock while the driver is active.
    bit track_en = 1'b0;
    int cur_run, max_run, runs, gap, min_gap;
    int cyc = 0;

    always @(negedge clk_ram) begin
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (owner !== e.owner || cpu_rdy !== e.rdy || cpu_rst !== e.rst ||
                scr_gnt !== e.gnt || ram_we !== e.we || ram_addr !== e.addr ||
                (e.chk_wd && ram_wdata !== e.wd)) begin
                fails++;
                $display("FAIL cycle%0d ph%0d: got own=%0d rdy=%b rst=%b gnt=%b we=%b a=%h d=%h required own=%0d rdy=%b rst=%b gnt=%b we=%b a=%h d=%h",
                         cyc, e.phase, owner, cpu_rdy, cpu_rst, scr_gnt, ram_we, ram_addr, ram_wdata,
                         e.owner, e.rdy, e.rst, e.gnt, e.we, e.addr, e.wd);
            end
        end
        if (!track_en) begin
            cur_run = 0; max_run = 0; runs = 0; gap = 0; min_gap = 1000;
        end else if (scr_gnt) begin
            if (cur_run == 0) begin
                if (runs > 0 && gap < min_gap) min_gap = gap;
                runs++;
            end
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            if (cur_run > 0) gap = 0;
            cur_run = 0;
            if (cpu_rdy) gap++;
        end
    end

    initial begin
        bit pr, sr, pd, rv;
        int rst_hold;
        model_reset();
        repeat (3) step(1'b0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);

        for (int i = 0; i < 12; i++) rstep(1'b0, 1'b0, 1'b0);
        $display("[TB] boot after reset release: %0d cycles, model phase %0d", 12, m_phase);

        track_en = 1'b1;
        for (int i = 0; i < 100; i++)
            step(1'b1, 0, 0, 0, 1, 1, 16'h0200, 8'($urandom), 16'($urandom), 8'($urandom), 16'(16'h8000 + i));
        @(negedge clk_ram);
        #1;
        check("screen max run length", 32'(max_run), 32'(SMH));
        tests++;
        if (runs < 2 || min_gap < CMR) begin
            fails++;
            $display("FAIL screen regrant: runs=%0d min_rdy_gap=%0d required runs>=2 gap>=%0d", runs, min_gap, CMR);
        end
        track_en = 1'b0;
        $display("[TB] screen hold 100 cycles: max grant run %0d, min CPU gap %0d", max_run, min_gap);

        wait_phase(PH_SCREEN, 1'b0, 1'b1, "reach SCREEN");
        step(1'b1, 1, 0, 1, 1, 0, 16'h1234, 8'h55, 16'h0600, 8'hA9, 16'h9000);
        step(1'b1, 1, 0, 1, 1, 0, 16'h1234, 8'h55, 16'h0600, 8'hA9, 16'h9000);
        #1;
        check("prog takeover owner", 32'(owner),     32'd2);
        check("prog takeover gnt",   32'(scr_gnt),   32'd0);
        check("prog write addr",     32'(ram_addr),  32'h0600);
        check("prog write data",     32'(ram_wdata), 32'hA9);
        check("prog write we",       32'(ram_we),    32'd1);
        repeat (3) rstep(1'b1, 1'b0, 1'b1);
        rstep(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) rstep(1'b0, 1'b0, 1'b0);
        $display("[TB] screen->prog takeover, upload, reboot: model phase %0d", m_phase);

        wait_phase(PH_PROG, 1'b1, 1'b0, "reach PROG (abort)");
        for (int i = 0; i < 6; i++) rstep(1'b0, 1'b0, 1'b0);
        $display("[TB] prog aborted without done: model phase %0d", m_phase);

        wait_phase(PH_PROG, 1'b1, 1'b0, "reach PROG (reset)");
        reset_mid_cycle();
        repeat (2) step(1'b0, 1, 0, 1, 0, 1, 16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
        for (int i = 0; i < 10; i++) rstep(1'b0, 1'b0, 1'b0);
        $display("[TB] asynchronous reset during PROG: model phase %0d", m_phase);

        pr = 1'b0; sr = 1'b0; rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) pr = !pr;
            if ($urandom_range(7) == 0) sr = !sr;
            pd = ($urandom_range(31) == 0);
            if (rst_hold == 0 && $urandom_range(599) == 0) rst_hold = 2;
            rv = (rst_hold == 0);
            if (rst_hold > 0) rst_hold--;
            step(rv, pr, pd, 1'($urandom), sr, 1'($urandom),
                 16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
        end
        $display("[TB] random traffic: %0d cycles", 3000);

        @(negedge clk_ram);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
